jump_input_conditioner: RTL

// Front-end for the player controls; feeds the start and user inputs of the game top level.
// It synchronises and debounces the two active-low push-buttons (start, jump).
// It emits a one-cycle start pulse per press.
// It holds a jump request until the control FSM acknowledges it or a timeout expires, so a press is not lost between WAIT_FOR_USER visits.

---
 rtl/jump_input_conditioner.sv | 98 +++++++++
 1 files changed

// File: rtl/jump_input_conditioner.sv
// jump_input_conditioner: synchronises and debounces the start/jump buttons, emits a start pulse,
// and holds a jump request until it is acknowledged or times out.
module jump_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       key_start_n,
    input  logic       key_jump_n,
    input  logic       jump_ack,
    output logic       start_pulse,
    output logic       jump_req,
    output logic [7:0] press_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;

    // Bit 0 is the start key, bit 1 the jump key; all key state is active-low like the buttons.
    logic [1:0]         raw;
    logic [1:0]         meta_q, sync_q, stable_q, stable_d, stable_dly_q, press;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    state_t             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               start_pulse_q, jump_req_q;
    logic [7:0]         press_count_q, press_count_d;

    assign raw   = {key_jump_n, key_start_n};
    assign press = stable_dly_q & ~stable_q;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            stable_d[k] = stable_q[k];
            cnt_d[k]    = '0;
            if (sync_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1))
                    stable_d[k] = sync_q[k];
                else
                    cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        press_count_d = press_count_q + {7'd0, press[1]};
        case (state_q)
            IDLE: begin
                if (press[1]) begin
                    state_d = REQ;
                    hold_d  = HW'(HOLD_CYCLES - 1);
                end
            end
            REQ: begin
                if (jump_ack || hold_q == '0)
                    state_d = WAIT_REL;
                else
                    hold_d = hold_q - 1'b1;
            end
            WAIT_REL: state_d = stable_q[1] ? IDLE : WAIT_REL;
            default:  state_d = IDLE;
        endcase
    end

    // Debounced keys reset to "pressed" so a key held through reset never yields an event.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            meta_q        <= '1;
            sync_q        <= '1;
            stable_q      <= '0;
            stable_dly_q  <= '0;
            cnt_q         <= '0;
            state_q       <= WAIT_REL;
            hold_q        <= '0;
            start_pulse_q <= 1'b0;
            jump_req_q    <= 1'b0;
            press_count_q <= '0;
        end else begin
            meta_q        <= raw;
            sync_q        <= meta_q;
            stable_q      <= stable_d;
            stable_dly_q  <= stable_q;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            hold_q        <= hold_d;
            start_pulse_q <= press[0];
            jump_req_q    <= state_d == REQ;
            press_count_q <= press_count_d;
        end
    end

    assign start_pulse = start_pulse_q;
    assign jump_req    = jump_req_q;
    assign press_count = press_count_q;
endmodule
